// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and controller states.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    FN_INC   = 3'd0,
    FN_ADD   = 3'd1,
    FN_SUB   = 3'd2,
    FN_LOGIC = 3'd3,
    FN_ANY   = 3'd4,
    FN_SHL   = 3'd5,
    FN_MUL   = 3'd6,
    FN_HOLD  = 3'd7
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_shift_add_mul.sv
// WIDTH-step shift-add multiplier. The final accumulation is presented
// combinationally on product while done is high, so the caller can register it.
module seq_shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic             active_q, active_d;
  logic [CW-1:0]    count_q, count_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    addend;

  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign product = acc_q + addend;
  assign done    = active_q && (count_q == CW'(WIDTH - 1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (go) begin
      active_d = 1'b1;
      count_d  = '0;
      mcand_d  = RW'(a);
      mplier_d = b;
      acc_d    = '0;
    end else if (active_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (done) active_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLOCK_50) begin
    if (reset) active_q <= 1'b0;
    else       active_q <= active_d;
  end

  // NOTE: datapath registers need no reset; they are fully loaded by go before use.
  always_ff @(posedge CLOCK_50) begin
    count_q  <= count_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

endmodule

// File: rtl/seq_alu_core.sv
// Registered ALU with start/busy/valid handshake, accumulate mode and a
// multi-cycle multiply delegated to seq_shift_add_mul.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           func,
  input  logic                 use_acc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [RW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;
  func_e            fn;
  logic             accept, mul_go, mul_done;
  logic [WIDTH-1:0] a_eff;
  logic [RW-1:0]    a_ext, b_ext, alu_out, mul_product;

  assign fn     = func_e'(func);
  assign accept = start && (state_q == IDLE);
  assign a_eff  = use_acc ? result_q[WIDTH-1:0] : a;
  assign a_ext  = RW'(a_eff);
  assign b_ext  = RW'(b);
  assign mul_go = accept && (fn == FN_MUL);

  seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .go       (mul_go),
    .a        (a_eff),
    .b        (b),
    .product  (mul_product),
    .done     (mul_done)
  );

  always_comb begin
    alu_out = result_q;
    case (fn)
      FN_INC:   alu_out = a_ext + RW'(1);
      FN_ADD:   alu_out = a_ext + b_ext;
      FN_SUB:   alu_out = a_ext - b_ext;
      FN_LOGIC: alu_out = {a_eff | b, a_eff ^ b};
      FN_ANY:   alu_out = RW'(|{a_eff, b});
      FN_SHL:   alu_out = (a_ext >= RW'(RW)) ? '0 : (b_ext << a_eff);
      default:  alu_out = result_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_go)   state_d = MUL;
      MUL:     if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MUL);
  end

  // Multiply completion and single-cycle acceptance are mutually exclusive.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (mul_done) begin
      result_d = mul_product;
      valid_d  = 1'b1;
    end else if (accept && (fn != FN_MUL)) begin
      result_d = alu_out;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
